// File: rtl/spw_link_ctrl_if.sv
// Host/core-facing signal bundle of the SpaceWire link controller.
// The slave modport is the controller's view; the master modport drives it.
interface spw_link_ctrl_if;
  logic       CMD_START;
  logic       CMD_STOP;
  logic [2:0] CURRENTSTATE;
  logic       LINK_START;
  logic       LINK_DISABLE;
  logic       AUTOSTART;
  logic       HOST_WR;
  logic [8:0] HOST_DATA;
  logic       HOST_BUSY;
  logic       WR_DATA;
  logic [8:0] DATA_I;
  logic       TX_FULL;
  logic       RD_DATA;
  logic       RX_EMPTY;
  logic [8:0] DATA_O;
  logic       HOST_RX_VALID;
  logic [8:0] HOST_RX_DATA;
  logic       HOST_RX_ACK;
  logic       LINK_UP;
  logic       LINK_FAIL;
  logic [2:0] RETRY_CNT;
  logic [7:0] DROP_CNT;

  modport slave (
    input  CMD_START, CMD_STOP, CURRENTSTATE, HOST_WR, HOST_DATA, TX_FULL,
           RX_EMPTY, DATA_O, HOST_RX_ACK,
    output LINK_START, LINK_DISABLE, AUTOSTART, HOST_BUSY, WR_DATA, DATA_I,
           RD_DATA, HOST_RX_VALID, HOST_RX_DATA, LINK_UP, LINK_FAIL,
           RETRY_CNT, DROP_CNT
  );

  modport master (
    output CMD_START, CMD_STOP, CURRENTSTATE, HOST_WR, HOST_DATA, TX_FULL,
           RX_EMPTY, DATA_O, HOST_RX_ACK,
    input  LINK_START, LINK_DISABLE, AUTOSTART, HOST_BUSY, WR_DATA, DATA_I,
           RD_DATA, HOST_RX_VALID, HOST_RX_DATA, LINK_UP, LINK_FAIL,
           RETRY_CNT, DROP_CNT
  );
endinterface

// File: rtl/spw_link_ctrl.sv
// SpaceWire link bring-up/retry controller with a 1-deep TX holding register
// and a single-outstanding-read RX path between the core FIFOs and the host.
module spw_link_ctrl #(
  parameter int START_TIMEOUT  = 20000,
  parameter int BACKOFF_CYCLES = 2560,
  parameter int MAX_RETRY      = 7
) (
  input  logic           CLOCK,
  input  logic           RESETn,
  spw_link_ctrl_if.slave lk
);
  localparam int TMAX = (START_TIMEOUT > BACKOFF_CYCLES) ? START_TIMEOUT : BACKOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] BACKOFF_LAST = TW'(BACKOFF_CYCLES - 1);
  localparam logic [2:0]    RETRY_LIM    = 3'(MAX_RETRY);
  localparam logic [2:0]    CS_RUN       = 3'd5;

  typedef enum logic [2:0] {S_OFF, S_START, S_RUN, S_BACKOFF, S_FAIL} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    retry_q, retry_d;
  logic [7:0]    drop_q, drop_d;
  logic          link_ok, in_run, link_on;

  assign link_ok = (lk.CURRENTSTATE == CS_RUN);
  assign in_run  = (state_q == S_RUN);
  assign link_on = (state_q == S_START) || in_run;

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_OFF;
      tmr_q   <= '0;
      retry_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
    end
  end

  // One timer serves both the start timeout and the backoff hold.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    drop_d  = drop_q;
    if (lk.CMD_STOP) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF, S_FAIL: if (lk.CMD_START) begin
          state_d = S_START;
          tmr_d   = '0;
          retry_d = '0;
        end
        S_START: begin
          if (link_ok) begin
            state_d = S_RUN;
            tmr_d   = '0;
          end else if (tmr_q == START_LAST) begin
            tmr_d = '0;
            if (retry_q == RETRY_LIM) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_BACKOFF;
              retry_d = retry_q + 3'd1;
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_RUN: if (!link_ok) begin
          state_d = S_BACKOFF;
          tmr_d   = '0;
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
        S_BACKOFF: begin
          if (tmr_q == BACKOFF_LAST) begin
            state_d = S_START;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  assign lk.LINK_START   = link_on;
  assign lk.AUTOSTART    = link_on;
  assign lk.LINK_DISABLE = !link_on;
  assign lk.LINK_UP      = in_run;
  assign lk.LINK_FAIL    = (state_q == S_FAIL);
  assign lk.RETRY_CNT    = retry_q;
  assign lk.DROP_CNT     = drop_q;

  // TX holding register: survives link drops, only reset discards it.
  logic       tx_full_q;
  logic [8:0] tx_data_q;
  logic       tx_wr;

  assign tx_wr        = tx_full_q && in_run && !lk.TX_FULL;
  assign lk.WR_DATA   = tx_wr;
  assign lk.DATA_I    = tx_data_q;
  assign lk.HOST_BUSY = tx_full_q;

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      tx_full_q <= 1'b0;
      tx_data_q <= '0;
    end else if (tx_wr) begin
      tx_full_q <= 1'b0;
    end else if (lk.HOST_WR && !tx_full_q) begin
      tx_full_q <= 1'b1;
      tx_data_q <= lk.HOST_DATA;
    end
  end

  // RX: the core FIFO presents DATA_O the cycle after RD_DATA; capture then.
  logic       rd_pend_q, rx_vld_q, rx_rd;
  logic [8:0] rx_data_q;

  assign rx_rd            = in_run && !lk.RX_EMPTY && !rx_vld_q && !rd_pend_q;
  assign lk.RD_DATA       = rx_rd;
  assign lk.HOST_RX_VALID = rx_vld_q;
  assign lk.HOST_RX_DATA  = rx_data_q;

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      rd_pend_q <= 1'b0;
      rx_vld_q  <= 1'b0;
      rx_data_q <= '0;
    end else begin
      rd_pend_q <= rx_rd;
      if (rd_pend_q) begin
        rx_vld_q  <= 1'b1;
        rx_data_q <= lk.DATA_O;
      end else if (rx_vld_q && lk.HOST_RX_ACK) begin
        rx_vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spw_link_ctrl.sv
// Randomized scoreboard bench for spw_link_ctrl: a phase/countdown reference
// model predicts every output each cycle; TX/RX characters are tracked in queues.
module tb_spw_link_ctrl;
  localparam int T = 16;
  localparam int B = 4;
  localparam int R = 2;
  localparam int P_OFF = 0, P_START = 1, P_RUN = 2, P_BACK = 3, P_FAIL = 4;

  logic CLOCK, RESETn;
  spw_link_ctrl_if lk();

  spw_link_ctrl #(.START_TIMEOUT(T), .BACKOFF_CYCLES(B), .MAX_RETRY(R)) dut (
    .CLOCK(CLOCK), .RESETn(RESETn), .lk(lk)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    bit rst, ld, ls, as, up, fl, busy, wr, rd, rxv;
    bit [2:0] rc;
    bit [7:0] dc;
    bit [8:0] di, rxd;
  } snap_t;

  int n_chk = 0, n_fail = 0, rd_cnt = 0;
  snap_t exp_q[$];
  bit [8:0] held[$], tx_exp[$], rx_exp[$], rx_src[$];
  int ph = P_OFF, left = 0, retries = 0, drops = 0, rx_st = 0;
  bit rx_vis = 0, rd_seen = 0, prev_v = 0, rx_fill_en = 0;
  bit [8:0] rx_char = 0;

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference model: expected outputs from the abstract link phase.
  function automatic snap_t expect_now();
    snap_t s;
    bit on;
    s = '0;
    if (!RESETn) begin
      s.rst = 1'b1;
      s.ld  = 1'b1;
      return s;
    end
    on     = (ph == P_START) || (ph == P_RUN);
    s.ld   = !on;
    s.ls   = on;
    s.as   = on;
    s.up   = (ph == P_RUN);
    s.fl   = (ph == P_FAIL);
    s.rc   = 3'(retries);
    s.dc   = 8'(drops);
    s.busy = held.size() != 0;
    s.wr   = s.busy && ph == P_RUN && !lk.TX_FULL;
    s.di   = s.wr ? held[0] : 9'h0;
    s.rd   = ph == P_RUN && !lk.RX_EMPTY && !rx_vis && rx_st == 0;
    s.rxv  = rx_vis;
    s.rxd  = rx_char;
    return s;
  endfunction

  task automatic model_step();
    snap_t s;
    if (!RESETn) begin
      ph = P_OFF; left = 0; retries = 0; drops = 0;
      held.delete(); tx_exp.delete(); rx_exp.delete();
      rx_st = 0; rx_vis = 0; rx_char = 0;
      return;
    end
    s = expect_now();
    if (s.wr) void'(held.pop_front());
    else if (lk.HOST_WR && held.size() == 0) begin
      held.push_back(lk.HOST_DATA);
      tx_exp.push_back(lk.HOST_DATA);
    end
    if (rx_st == 1) begin
      rx_char = lk.DATA_O; rx_vis = 1; rx_st = 0;
    end else if (rx_vis && lk.HOST_RX_ACK) rx_vis = 0;
    if (s.rd) rx_st = 1;
    if (lk.CMD_STOP) ph = P_OFF;
    else case (ph)
      P_OFF, P_FAIL: if (lk.CMD_START) begin ph = P_START; left = T; retries = 0; end
      P_START: if (lk.CURRENTSTATE == 5) ph = P_RUN;
        else begin
          left--;
          if (left == 0) begin
            if (retries == R) ph = P_FAIL;
            else begin ph = P_BACK; left = B; retries++; end
          end
        end
      P_RUN: if (lk.CURRENTSTATE != 5) begin
          ph = P_BACK; left = B;
          if (drops < 255) drops++;
        end
      default: begin
          left--;
          if (left == 0) begin ph = P_START; left = T; end
        end
    endcase
  endtask

  initial forever begin @(posedge CLOCK); model_step(); end
  initial forever begin @(negedge CLOCK); exp_q.push_back(expect_now()); end

  // Monitor: compare the DUT against the predicted snapshot and char queues.
  initial forever begin
    snap_t e;
    @(negedge CLOCK); #1;
    if (exp_q.size() == 0) fail("scoreboard_empty");
    else begin
      e = exp_q.pop_front();
      check("LINK_DISABLE", lk.LINK_DISABLE, e.ld);
      check("LINK_START", lk.LINK_START, e.ls);
      check("AUTOSTART", lk.AUTOSTART, e.as);
      check("LINK_UP", lk.LINK_UP, e.up);
      check("LINK_FAIL", lk.LINK_FAIL, e.fl);
      check("RETRY_CNT", lk.RETRY_CNT, e.rc);
      check("DROP_CNT", lk.DROP_CNT, e.dc);
      check("HOST_BUSY", lk.HOST_BUSY, e.busy);
      check("WR_DATA", lk.WR_DATA, e.wr);
      check("RD_DATA", lk.RD_DATA, e.rd);
      check("HOST_RX_VALID", lk.HOST_RX_VALID, e.rxv);
      if (e.rst || e.wr) check("DATA_I", lk.DATA_I, e.di);
      if (e.rst || e.rxv) check("HOST_RX_DATA", lk.HOST_RX_DATA, e.rxd);
    end
    rd_seen = RESETn && lk.RD_DATA;
    if (rd_seen) rd_cnt++;
    if (RESETn && lk.WR_DATA) begin
      if (tx_exp.size() == 0) fail("tx_unexpected_write");
      else check("tx_char", lk.DATA_I, tx_exp.pop_front());
    end
    if (RESETn && lk.HOST_RX_VALID && !prev_v) begin
      if (rx_exp.size() == 0) fail("rx_unexpected_valid");
      else check("rx_char", lk.HOST_RX_DATA, rx_exp.pop_front());
    end
    prev_v = RESETn && lk.HOST_RX_VALID;
  end

  // Core RX FIFO emulation: a read pops the next character onto DATA_O.
  initial forever begin
    @(posedge CLOCK); #1;
    if (rd_seen) begin
      if (rx_src.size() == 0) fail("rx_read_while_empty");
      else begin
        lk.DATA_O = rx_src.pop_front();
        rx_exp.push_back(lk.DATA_O);
      end
    end
    if (rx_fill_en && rx_src.size() < 3 && $urandom_range(0, 2) == 0)
      rx_src.push_back(9'($urandom_range(0, 511)));
    lk.RX_EMPTY = (rx_src.size() == 0);
  end

  task automatic step();
    @(posedge CLOCK); #1;
  endtask

  task automatic sample();
    @(negedge CLOCK); #1;
  endtask

  task automatic chk_reset(string tag);
    check({tag, "_LINK_DISABLE"}, lk.LINK_DISABLE, 1);
    check({tag, "_LINK_START"}, lk.LINK_START, 0);
    check({tag, "_AUTOSTART"}, lk.AUTOSTART, 0);
    check({tag, "_WR_DATA"}, lk.WR_DATA, 0);
    check({tag, "_RD_DATA"}, lk.RD_DATA, 0);
    check({tag, "_HOST_BUSY"}, lk.HOST_BUSY, 0);
    check({tag, "_HOST_RX_VALID"}, lk.HOST_RX_VALID, 0);
    check({tag, "_HOST_RX_DATA"}, lk.HOST_RX_DATA, 0);
    check({tag, "_DATA_I"}, lk.DATA_I, 0);
    check({tag, "_LINK_UP"}, lk.LINK_UP, 0);
    check({tag, "_LINK_FAIL"}, lk.LINK_FAIL, 0);
    check({tag, "_RETRY_CNT"}, lk.RETRY_CNT, 0);
    check({tag, "_DROP_CNT"}, lk.DROP_CNT, 0);
  endtask

  initial begin
    int rd0;
    RESETn = 1'b0;
    lk.CMD_START = 0; lk.CMD_STOP = 0; lk.CURRENTSTATE = 3'd0;
    lk.HOST_WR = 0; lk.HOST_DATA = '0; lk.TX_FULL = 0;
    lk.HOST_RX_ACK = 0; lk.DATA_O = '0; lk.RX_EMPTY = 1;
    repeat (3) step();
    sample();
    chk_reset("reset");
    step();
    RESETn = 1'b1;
    step();

    // Bring-up: link reaches Run 10 cycles after the start command.
    lk.CMD_START = 1; step(); lk.CMD_START = 0;
    sample(); check("bringup_link_start", lk.LINK_START, 1);
    repeat (9) step();
    lk.CURRENTSTATE = 3'd5;
    sample(); check("bringup_up_not_yet", lk.LINK_UP, 0);
    step();
    sample(); check("bringup_link_up", lk.LINK_UP, 1);
    check("bringup_retry", lk.RETRY_CNT, 0);

    // Randomized traffic with link flaps, commands and back-pressure.
    rx_fill_en = 1;
    repeat (3000) begin
      if ($urandom_range(0, 24) == 0) lk.CURRENTSTATE = 3'($urandom_range(0, 4));
      else if ($urandom_range(0, 3) == 0) lk.CURRENTSTATE = 3'd5;
      lk.CMD_START   = ($urandom_range(0, 59) == 0);
      lk.CMD_STOP    = ($urandom_range(0, 149) == 0);
      lk.HOST_WR     = ($urandom_range(0, 2) == 0);
      lk.HOST_DATA   = 9'($urandom_range(0, 511));
      lk.TX_FULL     = ($urandom_range(0, 3) == 0);
      lk.HOST_RX_ACK = 1'($urandom_range(0, 1));
      step();
    end
    rx_fill_en = 0;
    lk.CMD_START = 0; lk.HOST_WR = 0; lk.TX_FULL = 0; lk.HOST_RX_ACK = 1;
    lk.CMD_STOP = 1; step(); lk.CMD_STOP = 0;
    repeat (4) step();
    rx_src.delete();
    repeat (4) step();

    // Drop counting, saturating at 255.
    lk.CURRENTSTATE = 3'd5;
    lk.CMD_START = 1; step(); lk.CMD_START = 0; step();
    repeat (260) begin
      lk.CURRENTSTATE = 3'd0; step();
      lk.CURRENTSTATE = 3'd5; repeat (6) step();
    end
    sample();
    check("drop_saturated", lk.DROP_CNT, 255);
    check("drop_link_up_again", lk.LINK_UP, 1);

    // TX flow control; the second write while busy is lost.
    lk.TX_FULL = 1;
    lk.HOST_WR = 1; lk.HOST_DATA = 9'h1AB; step();
    lk.HOST_WR = 1; lk.HOST_DATA = 9'h0CD; step();
    lk.HOST_WR = 0;
    sample(); check("tx_busy", lk.HOST_BUSY, 1);
    repeat (8) begin
      step();
      sample(); check("tx_blocked", lk.WR_DATA, 0);
    end
    step();
    lk.TX_FULL = 0;
    sample(); check("tx_write", lk.WR_DATA, 1);
    check("tx_data", lk.DATA_I, 9'h1AB);
    step();
    sample(); check("tx_write_once", lk.WR_DATA, 0);
    check("tx_busy_clear", lk.HOST_BUSY, 0);

    // RX handshake: no second read until the host acknowledges.
    lk.HOST_RX_ACK = 0;
    rd0 = rd_cnt;
    rx_src.push_back(9'h055);
    repeat (8) step();
    sample(); check("rx_valid", lk.HOST_RX_VALID, 1);
    check("rx_data", lk.HOST_RX_DATA, 9'h055);
    check("rx_single_read", rd_cnt - rd0, 1);
    rx_src.push_back(9'h0AA);
    repeat (5) step();
    sample(); check("rx_hold_no_read", rd_cnt - rd0, 1);
    check("rx_data_held", lk.HOST_RX_DATA, 9'h055);
    step();
    lk.HOST_RX_ACK = 1; step(); lk.HOST_RX_ACK = 0;
    sample(); check("rx_valid_fall", lk.HOST_RX_VALID, 0);
    repeat (4) step();
    sample(); check("rx_second", lk.HOST_RX_DATA, 9'h0AA);
    lk.HOST_RX_ACK = 1; step(); lk.HOST_RX_ACK = 0; step();

    // Stop beats start in the same cycle.
    lk.CMD_START = 1; lk.CMD_STOP = 1; step();
    lk.CMD_START = 0; lk.CMD_STOP = 0;
    sample(); check("prio_off_disable", lk.LINK_DISABLE, 1);
    check("prio_off_up", lk.LINK_UP, 0);
    check("prio_drops_held", lk.DROP_CNT, 255);

    // Three timeouts with the core stuck in Started -> FAIL.
    lk.CURRENTSTATE = 3'd3;
    lk.CMD_START = 1; step(); lk.CMD_START = 0;
    repeat (3 * T + 2 * B + 3) step();
    sample(); check("retry_fail", lk.LINK_FAIL, 1);
    check("retry_cnt", lk.RETRY_CNT, R);
    check("retry_disable", lk.LINK_DISABLE, 1);

    // Asynchronous reset in RUN with a held TX char and a pending RX char.
    lk.CURRENTSTATE = 3'd5;
    lk.CMD_START = 1; step(); lk.CMD_START = 0; step();
    lk.TX_FULL = 1; lk.HOST_RX_ACK = 0;
    lk.HOST_WR = 1; lk.HOST_DATA = 9'h123; step(); lk.HOST_WR = 0;
    rx_src.push_back(9'h0F0);
    repeat (6) step();
    sample(); check("pre_reset_busy", lk.HOST_BUSY, 1);
    check("pre_reset_rx_valid", lk.HOST_RX_VALID, 1);
    @(negedge CLOCK); #2;
    RESETn = 1'b0;
    #1;
    chk_reset("async_reset");
    step();
    RESETn = 1'b1; lk.TX_FULL = 0;
    repeat (3) step();
    sample(); check("post_reset_busy", lk.HOST_BUSY, 0);
    check("post_reset_rx_valid", lk.HOST_RX_VALID, 0);
    check("post_reset_off", lk.LINK_DISABLE, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
